// File: rtl/lsu_pkg.sv
// Shared types for the LSU RAM controller: size/state enums and lane helpers.
// Misalignment trapping is enabled by defining LSU_MISALIGN_CHECK_EN.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  function automatic logic [3:0] lane_mask(size_e sz);
    unique case (sz)
      SZ_BYTE: lane_mask = LANE_B;
      SZ_HALF: lane_mask = LANE_H;
      default: lane_mask = LANE_W;
    endcase
  endfunction

  // Byte offset with the low bits a half/word cannot use forced to zero.
  function automatic logic [1:0] lane_off(size_e sz, logic [1:0] a);
    unique case (sz)
      SZ_BYTE: lane_off = a;
      SZ_HALF: lane_off = {a[1], 1'b0};
      default: lane_off = 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(size_e sz, logic [1:0] a);
    unique case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = a[0];
      default: misaligned = (a != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract with sign/zero extension, and byte-lane store merge.
// Purely combinational; the offset is already aligned to the access size.
module lsu_align
  import lsu_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  off_i,
  input  logic        uns_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] mdata_o
);

  logic [3:0]  be;
  logic [31:0] sh_r;
  logic [31:0] sh_w;

  always_comb begin
    be   = lane_mask(size_i) << off_i;
    sh_r = rdata_i >> {off_i, 3'b000};
    sh_w = wdata_i << {off_i, 3'b000};
  end

  always_comb begin
    unique case (size_i)
      SZ_BYTE:
        ldata_o = uns_i ? {24'h0, sh_r[7:0]}
                        : {{24{sh_r[7]}}, sh_r[7:0]};
      SZ_HALF:
        ldata_o = uns_i ? {16'h0, sh_r[15:0]}
                        : {{16{sh_r[15]}}, sh_r[15:0]};
      default:
        ldata_o = sh_r;
    endcase
  end

  always_comb begin
    mdata_o = rdata_i;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mdata_o[8*i +: 8] = sh_w[8*i +: 8];
    end
  end

endmodule

// File: rtl/lsu_ram_ctrl.sv
// Single-outstanding load/store unit in front of a 32-bit word RAM.
// Define LSU_MISALIGN_CHECK_EN to flag misaligned halves/words as errors.
module lsu_ram_ctrl
  import lsu_pkg::*;
#(
  parameter int RAM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [RAM_AW-1:0] ram_raddr,
  input  logic [31:0]       ram_rdata,
  output logic [RAM_AW-1:0] ram_waddr,
  output logic [31:0]       ram_wdata,
  output logic              ram_wen
);

  state_e              state_q, state_d;
  logic                wen_q;
  logic [RAM_AW+1:0]   addr_q;
  logic [31:0]         wdata_q;
  size_e               size_q;
  logic                uns_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic [RAM_AW-1:0]   idx;
  logic [1:0]          off;
  logic                mis;
  logic [31:0]         ldata;
  logic [31:0]         mdata;
  logic                accept;
  logic                unused_addr;

  // Address bits above the RAM window are deliberately ignored.
  assign unused_addr = ^req_addr[31:RAM_AW+2];

  assign accept = req_valid && req_ready;
  assign idx    = addr_q[RAM_AW+1:2];
  assign off    = lane_off(size_q, addr_q[1:0]);

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis = misaligned(size_q, addr_q[1:0]);
`else
  assign mis = 1'b0;
`endif

  lsu_align u_align (
    .size_i  (size_q),
    .off_i   (off),
    .uns_i   (uns_q),
    .rdata_i (ram_rdata),
    .wdata_i (wdata_q),
    .ldata_o (ldata),
    .mdata_o (mdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr[RAM_AW+1:0];
        wdata_q <= req_wdata;
        size_q  <= size_e'(req_size);
        uns_q   <= req_unsigned;
      end
      if (state_q == S_ACCESS) begin
        rdata_q <= (wen_q || mis) ? 32'h0 : ldata;
        err_q   <= mis;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    ram_raddr = '0;
    ram_waddr = '0;
    ram_wdata = '0;
    ram_wen   = 1'b0;
    if (state_q == S_ACCESS) begin
      ram_raddr = idx;
      ram_waddr = idx;
      if (wen_q && !mis) begin
        ram_wdata = mdata;
        ram_wen   = !rst;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Directed table-driven bench for lsu_ram_ctrl with a behavioural RAM.
// Expectations follow LSU_MISALIGN_CHECK_EN when it is defined.
module tb_lsu_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  ram_raddr, ram_waddr;
  logic [31:0] ram_rdata, ram_wdata;
  logic        ram_wen;

  always #5 clk = ~clk;

  lsu_ram_ctrl #(.RAM_AW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ram_raddr    (ram_raddr),
    .ram_rdata    (ram_rdata),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .ram_wen      (ram_wen)
  );

  logic [31:0] mem [256];
  int          wen_cnt = 0;

  assign ram_rdata = mem[ram_raddr];

  always @(posedge clk) begin
    if (ram_wen) begin
      mem[ram_waddr] <= ram_wdata;
      wen_cnt <= wen_cnt + 1;
    end
  end

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] exp_rd;
    bit          exp_err;
    int          stall;
    bit          mchk;
    int          midx;
    logic [31:0] mexp;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  function automatic vec_t mk(bit wen, logic [31:0] addr,
                              logic [31:0] wdata, logic [1:0] size,
                              bit uns, logic [31:0] exp_rd,
                              bit exp_err, int stall, bit mchk,
                              int midx, logic [31:0] mexp);
    vec_t v;
    v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.size = size; v.uns = uns; v.exp_rd = exp_rd;
    v.exp_err = exp_err; v.stall = stall;
    v.mchk = mchk; v.midx = midx; v.mexp = mexp;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic run_req(vec_t v, string nm);
    exp_t e, g;
    int   cyc, w0;
    logic wen_seen;
    @(negedge clk);
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr;
    req_wdata = v.wdata; req_size = v.size; req_unsigned = v.uns;
    e.rd = v.exp_rd; e.err = v.exp_err;
    sb.push_back(e);
    w0 = wen_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    wen_seen = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) wen_seen = ram_wen;
    end while (!rsp_valid && cyc < 8);
    chk({nm, " latency"}, 32'(cyc), 32'd2);
    chk({nm, " ram_wen"}, 32'(wen_seen),
        32'(v.wen && !v.exp_err));
    chk({nm, " wen_cycles"}, 32'(wen_cnt - w0),
        32'(v.wen && !v.exp_err));
    g = sb.pop_front();
    chk({nm, " rdata"}, rsp_rdata, g.rd);
    chk({nm, " err"}, 32'(rsp_err), 32'(g.err));
    for (int i = 0; i < v.stall; i++) begin
      @(negedge clk);
      chk({nm, " stall_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, " stall_rdata"}, rsp_rdata, g.rd);
      chk({nm, " stall_rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    if (v.mchk) chk({nm, " mem"}, mem[v.midx], v.mexp);
  endtask

  logic [31:0] old8, fin8;
  int          w_rst;
  bit          mis_en;

  initial begin
`ifdef LSU_MISALIGN_CHECK_EN
    mis_en = 1'b1;
`else
    mis_en = 1'b0;
`endif
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0;
    req_addr = '0; req_wdata = '0; req_size = '0;
    req_unsigned = 1'b0; rsp_ready = 1'b0;

    vt.push_back(mk(1, 32'h10, 32'hDEADBEEF, 2, 0, 0, 0, 0,
                    1, 4, 32'hDEADBEEF));
    vt.push_back(mk(0, 32'h10, 0, 2, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h10, 32'h11223344, 2, 0, 0, 0, 0,
                    1, 4, 32'h11223344));
    vt.push_back(mk(1, 32'h13, 32'hFFFFFF7A, 0, 0, 0, 0, 0,
                    1, 4, 32'h7A223344));
    vt.push_back(mk(0, 32'h13, 0, 0, 0, 32'h7A, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h11, 32'h12345680, 0, 0, 0, 0, 0,
                    1, 4, 32'h7A228044));
    vt.push_back(mk(0, 32'h11, 0, 0, 0, 32'hFFFFFF80, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 32'h11, 0, 0, 1, 32'h80, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h20, 0, 2, 0, 0, 0, 0, 1, 8, 0));
    vt.push_back(mk(1, 32'h22, 32'hAAAABEEF, 1, 0, 0, 0, 0,
                    1, 8, 32'hBEEF0000));
    vt.push_back(mk(0, 32'h22, 0, 1, 0, 32'hFFFFBEEF, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 32'h22, 0, 1, 1, 32'h0000BEEF, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 32'h410, 0, 2, 0, 32'h7A228044, 0, 5, 0, 0, 0));
    vt.push_back(mk(0, 32'h12, 0, 0, 0, 32'h22, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 32'h10, 0, 1, 1, 32'h8044, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 32'h10, 0, 3, 0, 32'h7A228044, 0, 0, 0, 0, 0));
    vt.push_back(mk(1, 32'h20, 32'h00001357, 1, 0, 0, 0, 0,
                    1, 8, 32'hBEEF1357));
    vt.push_back(mk(0, 32'h23, 0, 0, 0, 32'hFFFFFFBE, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    chk("rst ram_wen", 32'(ram_wen), 32'd0);
    chk("rst ram_wdata", ram_wdata, 32'd0);
    chk("rst ram_raddr", 32'(ram_raddr), 32'd0);

    for (int i = 0; i < vt.size(); i++)
      run_req(vt[i], $sformatf("vec%0d", i));

    fin8 = mis_en ? 32'hBEEF1357 : 32'h12345678;
    run_req(mk(1, 32'h21, 32'h12345678, 2, 0, 0, mis_en, 0,
               1, 8, fin8), "mis_store");
    run_req(mk(0, 32'h23, 0, 1, 1, mis_en ? 32'h0 : 32'h1234,
               mis_en, 0, 0, 0, 0), "mis_half");

    old8 = mem[8];
    w_rst = wen_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h20;
    req_wdata = 32'hCAFEF00D; req_size = 2'd2;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstacc ram_wen", 32'(ram_wen), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstacc req_ready", 32'(req_ready), 32'd1);
    chk("rstacc rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstacc rsp_rdata", rsp_rdata, 32'd0);
    chk("rstacc mem", mem[8], old8);
    chk("rstacc wen_cnt", 32'(wen_cnt), 32'(w_rst));

    run_req(mk(0, 32'h20, 0, 2, 0, fin8, 0, 0, 0, 0, 0), "post_rst");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_ram_ctrl.md
LSU_RAM_CTRL -- requirements
Module: lsu_ram_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 8, meaning the RAM word-address width (256 words).
REQ-002 SHALL have the following ports, listed as name, direction, width, meaning:
- clk, input, 1, the single clock; all state updates on posedge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, request accepted when high with req_valid.
- req_wen, input, 1, 1 = store, 0 = load.
- req_addr, input, 32, byte address.
- req_wdata, input, 32, store data, right-aligned.
- req_size, input, 2, 0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- req_unsigned, input, 1, zero-extend load when 1.
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, response consumed when high with rsp_valid.
- rsp_rdata, output, 32, extended load data; 0 for stores.
- rsp_err, output, 1, misaligned access flag.
- ram_raddr, output, RAM_AW, RAM read word address.
- ram_rdata, input, 32, RAM read data, combinational from ram_raddr.
- ram_waddr, output, RAM_AW, RAM write word address.
- ram_wdata, output, 32, RAM write data.
- ram_wen, output, 1, RAM write enable; the write commits on the next posedge.

Function
REQ-003 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-004 SHALL drive req_ready = 1 only in IDLE.
REQ-005 On req_valid && req_ready, SHALL latch wen, addr, wdata, size and unsigned, then go to ACCESS.
REQ-006 SHALL use word index = latched addr[RAM_AW+1:2] and ignore higher address bits.
REQ-007 In ACCESS, SHALL drive ram_raddr = ram_waddr = index.
REQ-008 In ACCESS for a load, SHALL select the lane by addr[1:0], sign- or zero-extend it, register it into rsp_rdata, and go to RESP.
REQ-009 In ACCESS for a store, SHALL assert ram_wen for exactly one cycle, then go to RESP.
- Word store: ram_wdata = wdata.
- Byte or half store: ram_wdata = ram_rdata with only the addressed lane(s) replaced by the low bits of wdata (same-cycle read-modify-write).
REQ-010 In RESP, SHALL hold rsp_valid = 1 with rsp_rdata and rsp_err stable until rsp_ready; on rsp_ready go to IDLE.
REQ-011 Latency SHALL be: accept at edge N, RAM access in cycle N+1, rsp_valid from cycle N+2; maximum throughput is one request per 3 cycles.
REQ-012 SHALL never assert ram_wen outside ACCESS, nor in any cycle where rst = 1.
REQ-013 Outside ACCESS, ram_raddr, ram_waddr and ram_wdata SHALL be 0.

Reset
REQ-014 With rst high at a posedge, SHALL set state to IDLE, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 and all latched request fields to 0.
REQ-015 Reset in ACCESS SHALL suppress the pending write (per REQ-012); reset in RESP SHALL drop the response.

Configuration
REQ-016 Macro LSU_MISALIGN_CHECK_EN SHALL control misalignment handling.
- Defined: a half with addr[0] = 1, or a word with addr[1:0] != 0, performs no RAM write; the response has rsp_err = 1 and rsp_rdata = 0, with the same latency.
- Undefined: rsp_err is tied to 0, and misaligned halves and words use addr with its low bits forced to 0.

Structure
REQ-017 Package lsu_pkg SHALL hold the size encoding enum, the FSM state enum and the lane-select constants.
REQ-018 Combinational sub-module lsu_align SHALL perform lane extract, extension and store merge; the FSM and registers stay in lsu_ram_ctrl.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Word store 0xDEADBEEF at addr 0x10, then word load at 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid two cycles after accept.
- Byte store 0x7A at 0x13 over word 0x11223344 -> RAM word 4 = 0x7A223344; signed byte load at 0x13 -> 0x0000007A; byte store 0x80 at 0x11 then signed byte load -> 0xFFFFFF80, unsigned -> 0x00000080.
- Half store 0xBEEF at 0x22 over 0 -> word 8 = 0xBEEF0000; signed half load at 0x22 -> 0xFFFFBEEF.
- With LSU_MISALIGN_CHECK_EN, word store at 0x21 -> rsp_err = 1, ram_wen never asserted, RAM unchanged; without the macro -> store lands at word 8.
- rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout; a new request is accepted only after the handshake.
- rst asserted in the ACCESS cycle of a store -> no RAM write, next cycle req_ready = 1 and rsp_valid = 0.
